puf_response_packer: RTL and testbench

- Downstream consumer of wrapper_puf. Captures the RESPONSE_SIZE-bit PUF_RESPONSE when the PUF raises DONE, then streams it out as WORD_SIZE-bit words over a valid/ready handshake to the authentication datapath (key register / bus bridge).
- Decouples the PUF's level-style DONE from a backpressured word interface, flags lost responses, and frees the PUF to start the next challenge as soon as the capture is done.

---
 rtl/puf_pkg.sv | 19 +
 rtl/puf_done_edge.sv | 30 +++
 rtl/puf_response_packer.sv | 116 +++++++++++
 tb/tb_puf_response_packer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared constants for the PUF subsystem (wrapper_puf and its consumers).
//   - Default response / word / challenge / helper-data widths.
//   - Two-state encoding used by puf_response_packer.
// -----------------------------------------------------------------------------
package puf_pkg;

  localparam int PUF_RESPONSE_SIZE    = 256;
  localparam int PUF_WORD_SIZE        = 32;
  localparam int PUF_CHALLENGE_SIZE   = 64;
  localparam int PUF_HELPER_DATA_SIZE = 128;

  typedef enum logic {
    PK_IDLE = 1'b0,
    PK_SEND = 1'b1
  } pk_state_e;

endpackage : puf_pkg

// File: rtl/puf_done_edge.sv
// -----------------------------------------------------------------------------
// puf_done_edge
// Turns the level-style DONE of wrapper_puf into a one-cycle capture event.
// done_q resets to 0, so a DONE already high at reset release counts as a rise
// on the first clock.
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   i_done  in   DONE level from the PUF
//   o_rise  out  i_done & ~done_q (combinational)
// -----------------------------------------------------------------------------
module puf_done_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_done,
  output logic o_rise
);

  logic r_done_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done_q <= 1'b0;
    else        r_done_q <= i_done;
  end

  assign o_rise = i_done & ~r_done_q;

endmodule : puf_done_edge

// File: rtl/puf_response_packer.sv
// -----------------------------------------------------------------------------
// puf_response_packer
// Captures a RESPONSE_SIZE-bit PUF response on each DONE rise and streams it
// out LSW first as WORD_SIZE-bit words over a valid/ready handshake.
// RESPONSE_SIZE must be an integer multiple of WORD_SIZE.
// Ports:
//   CLK           in   system clock, rising edge
//   RST           in   asynchronous active-low reset
//   PUF_DONE      in   DONE level from wrapper_puf
//   PUF_RESPONSE  in   response, valid while PUF_DONE is high
//   WORD_DATA     out  current output word (holds last value when idle)
//   WORD_VALID    out  WORD_DATA is valid
//   WORD_READY    in   sink accepts the word this cycle
//   WORD_LAST     out  final word of a response
//   BUSY          out  a response is held or being streamed
//   OVERRUN       out  sticky: a response arrived while busy and was dropped
//   CLR_OVERRUN   in   synchronous clear of OVERRUN (a new overrun wins)
// -----------------------------------------------------------------------------
module puf_response_packer
  import puf_pkg::*;
#(
  parameter int RESPONSE_SIZE = PUF_RESPONSE_SIZE,
  parameter int WORD_SIZE     = PUF_WORD_SIZE
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PUF_DONE,
  input  logic [RESPONSE_SIZE-1:0] PUF_RESPONSE,
  output logic [WORD_SIZE-1:0]     WORD_DATA,
  output logic                     WORD_VALID,
  input  logic                     WORD_READY,
  output logic                     WORD_LAST,
  output logic                     BUSY,
  output logic                     OVERRUN,
  input  logic                     CLR_OVERRUN
);

  localparam int NUM_WORDS = RESPONSE_SIZE / WORD_SIZE;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  pk_state_e                            r_state;
  logic [IDX_W-1:0]                     r_idx;
  logic [WORD_SIZE-1:0]                 r_data;
  logic                                 r_last;
  logic                                 r_overrun;
  logic [NUM_WORDS-1:0][WORD_SIZE-1:0]  r_hold;

  logic             w_rise;
  logic             w_hs;
  logic             w_final;
  logic             w_load;
  logic [IDX_W-1:0] w_next_idx;

  puf_done_edge u_done_edge (
    .clk    (CLK),
    .rst_n  (RST),
    .i_done (PUF_DONE),
    .o_rise (w_rise)
  );

  assign w_hs       = (r_state == PK_SEND) & WORD_READY;
  assign w_final    = w_hs & r_last;
  // A rise is accepted when idle, or when it lands on the final handshake so
  // back-to-back responses stream without a valid bubble.
  assign w_load     = w_rise & ((r_state == PK_IDLE) | w_final);
  assign w_next_idx = r_idx + 1'b1;

  // NOTE: the hold register is pure datapath and is only read after a load,
  // so it carries no reset; this keeps the wide register off the reset tree.
  always_ff @(posedge CLK) begin
    if (w_load) r_hold <= PUF_RESPONSE;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= PK_IDLE;
      r_idx     <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (CLR_OVERRUN) r_overrun <= 1'b0;

      if (w_load) begin
        // Word 0 comes straight from the input so it is valid next cycle.
        r_state <= PK_SEND;
        r_idx   <= '0;
        r_data  <= PUF_RESPONSE[WORD_SIZE-1:0];
        r_last  <= (NUM_WORDS == 1);
      end else begin
        case (r_state)
          PK_IDLE: ;
          PK_SEND: begin
            // Rise mid-stream: drop the new response, keep streaming.
            if (w_rise) r_overrun <= 1'b1;
            if (w_final) begin
              r_state <= PK_IDLE;
              r_last  <= 1'b0;
            end else if (w_hs) begin
              r_idx  <= w_next_idx;
              r_data <= r_hold[w_next_idx];
              r_last <= (w_next_idx == IDX_W'(NUM_WORDS - 1));
            end
          end
        endcase
      end
    end
  end

  assign WORD_DATA  = r_data;
  assign WORD_VALID = (r_state == PK_SEND);
  assign BUSY       = (r_state == PK_SEND);
  assign WORD_LAST  = r_last;
  assign OVERRUN    = r_overrun;

endmodule : puf_response_packer

// File: tb/tb_puf_response_packer.sv
// -----------------------------------------------------------------------------
// tb_puf_response_packer
// Directed bench for puf_response_packer with hand-written expected words.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_puf_response_packer;

  logic         CLK;
  logic         RST;
  logic         PUF_DONE;
  logic [255:0] PUF_RESPONSE;
  logic [31:0]  WORD_DATA;
  logic         WORD_VALID;
  logic         WORD_READY;
  logic         WORD_LAST;
  logic         BUSY;
  logic         OVERRUN;
  logic         CLR_OVERRUN;

  puf_response_packer #(
    .RESPONSE_SIZE (256),
    .WORD_SIZE     (32)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .PUF_DONE     (PUF_DONE),
    .PUF_RESPONSE (PUF_RESPONSE),
    .WORD_DATA    (WORD_DATA),
    .WORD_VALID   (WORD_VALID),
    .WORD_READY   (WORD_READY),
    .WORD_LAST    (WORD_LAST),
    .BUSY         (BUSY),
    .OVERRUN      (OVERRUN),
    .CLR_OVERRUN  (CLR_OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int done_hold = 0;   // remaining clock edges with PUF_DONE driven high
  bit exp_ov = 1'b0;   // expected OVERRUN

  logic [31:0] words_a [8] = '{32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 32'hCAFEF00D,
                               32'h12345678, 32'h0BADC0DE, 32'hFEEDFACE, 32'h76543210};
  logic [31:0] exp_w [8];
  logic [7:0][31:0] resp_a;
  logic [7:0][31:0] resp_b;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Drive inputs for the next rising edge, then return at the following falling edge.
  task automatic step(input logic rdy);
    WORD_READY = rdy;
    PUF_DONE   = (done_hold > 0);
    if (done_hold > 0) done_hold--;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(WORD_VALID), 32'd0);
    check({tag, "_busy"},  32'(BUSY),       32'd0);
    check({tag, "_last"},  32'(WORD_LAST),  32'd0);
  endtask

  // Consume one 8-word stream from exp_w. Called at the falling edge where
  // word 0 must already be valid. mode 0: ready always 1; mode 1: ready 1,0,0,...
  // inject_at >= 0 raises DONE with inj_resp while word inject_at is pending.
  task automatic consume(input int mode, input int inject_at, input bit inj_ovr,
                         input logic [255:0] inj_resp, input string tag);
    int   cnt = 0;
    int   i   = 0;
    bit   injected = 1'b0;
    bit   now_inj;
    logic rdy;
    while (cnt < 8 && i < 40) begin
      check({tag, "_valid"},   32'(WORD_VALID), 32'd1);
      check({tag, "_busy"},    32'(BUSY),       32'd1);
      check({tag, "_data"},    WORD_DATA,       exp_w[cnt]);
      check({tag, "_last"},    32'(WORD_LAST),  32'(cnt == 7));
      check({tag, "_overrun"}, 32'(OVERRUN),    32'(exp_ov));
      rdy = (mode == 0) ? 1'b1 : ((i % 3) == 0);
      now_inj = 1'b0;
      if (!injected && cnt == inject_at) begin
        PUF_RESPONSE = inj_resp;
        done_hold    = 3;
        injected     = 1'b1;
        now_inj      = 1'b1;
      end
      if (rdy) cnt++;
      step(rdy);
      if (now_inj && inj_ovr) exp_ov = 1'b1;
      i++;
    end
    check({tag, "_count"}, 32'(cnt), 32'd8);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      resp_a[k] = words_a[k];
      resp_b[k] = 32'hA5A5A5A5;
    end
    RST = 1'b0; PUF_DONE = 1'b0; WORD_READY = 1'b0; CLR_OVERRUN = 1'b0;
    PUF_RESPONSE = resp_a;
    @(negedge CLK);
    @(negedge CLK);

    // Reset state
    check_idle("reset");
    check("reset_data",    WORD_DATA,      32'd0);
    check("reset_overrun", 32'(OVERRUN),   32'd0);
    RST = 1'b1;
    step(1'b0);
    check_idle("post_reset");

    // Basic: DONE high 10 cycles, ready high, exactly one 8-word stream
    for (int k = 0; k < 8; k++) exp_w[k] = words_a[k];
    done_hold = 10;
    step(1'b1);
    consume(0, -1, 1'b0, '0, "basic");
    check_idle("basic_end");
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      check("basic_no_second", 32'(WORD_VALID), 32'd0);
    end

    // Backpressure: ready 1,0,0,... ; words held while stalled
    done_hold = 2;
    step(1'b1);
    consume(1, -1, 1'b0, '0, "bp");
    check_idle("bp_end");
    step(1'b0);
    step(1'b0);

    // Overrun: rise while word 3 pending, original stream completes
    done_hold = 2;
    step(1'b1);
    consume(1, 3, 1'b1, resp_b, "ovr");
    check_idle("ovr_end");
    check("ovr_sticky", 32'(OVERRUN), 32'd1);
    step(1'b0);
    check("ovr_idle_valid", 32'(WORD_VALID), 32'd0);
    CLR_OVERRUN = 1'b1;
    step(1'b0);
    CLR_OVERRUN = 1'b0;
    exp_ov = 1'b0;
    check("ovr_cleared", 32'(OVERRUN), 32'd0);
    step(1'b0);

    // Back-to-back: rise on the final handshake, new stream with no bubble
    PUF_RESPONSE = resp_a;
    done_hold = 2;
    step(1'b1);
    consume(0, 7, 1'b0, resp_b, "b2b_first");
    for (int k = 0; k < 8; k++) exp_w[k] = 32'hA5A5A5A5;
    consume(0, -1, 1'b0, '0, "b2b_second");
    check_idle("b2b_end");
    check("b2b_overrun", 32'(OVERRUN), 32'd0);
    step(1'b0);
    step(1'b0);

    // Reset mid-stream after word 2
    PUF_RESPONSE = resp_a;
    for (int k = 0; k < 8; k++) exp_w[k] = words_a[k];
    done_hold = 1;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check("rst_mid_word3", WORD_DATA, words_a[3]);
    #2 RST = 1'b0;
    #1;
    check_idle("rst_mid");
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      check("rst_mid_no_residual", 32'(WORD_VALID), 32'd0);
    end

    // DONE high across reset release: single capture, word 0 after first edge
    RST = 1'b0;
    done_hold = 30;
    step(1'b1);
    step(1'b1);
    check("done_in_reset_valid", 32'(WORD_VALID), 32'd0);
    RST = 1'b1;
    #1;
    check("release_valid", 32'(WORD_VALID), 32'd0);
    step(1'b1);
    consume(0, -1, 1'b0, '0, "release");
    check_idle("release_end");
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      check("release_single_capture", 32'(WORD_VALID), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_puf_response_packer
